pcie_bar_completer: RTL and testbench
=====================================

# pcie_bar_completer

Hardware completer for BAR0 memory requests arriving on the PCIe endpoint's receive AXI-Stream. It decodes 3DW memory read and memory write TLPs and maintains a 16 x 32-bit register file. It answers reads with completion TLPs on the endpoint's transmit AXI-Stream, making it the responder for the host-initiated requests. It sits between the 7-series PCIe core's `m_axis_rx_*` / `s_axis_tx_*` ports and fabric logic that consumes the register file.

## Interface
- `ID_VALUE`, default 32'h5A43_0001, read-only contents of register 0.
- `user_clk`  in  1  PCIe core user clock; all logic on rising edge.
- `user_reset_n`  in  1  asynchronous, active-low reset.
- `completer_id`  in  16  {bus, device, function} placed in completion headers.
- `m_axis_rx_tdata`  in  64  RX TLP data; DW0 in [31:0], DW1 in [63:32].
- `m_axis_rx_tkeep`  in  8  RX byte enables.
- `m_axis_rx_tlast`  in  1  last RX beat.
- `m_axis_rx_tvalid`  in  1  RX beat valid.
- `m_axis_rx_tuser`  in  22  core sideband; bit 2 = BAR0 hit.
- `m_axis_rx_tready`  out  1  RX beat accepted.
- `s_axis_tx_tdata`  out  64  TX completion data.
- `s_axis_tx_tkeep`  out  8  TX byte enables.
- `s_axis_tx_tlast`  out  1  last TX beat.
- `s_axis_tx_tvalid`  out  1  TX beat valid.
- `s_axis_tx_tready`  in  1  core accepts TX beat.
- `regs_flat`  out  512  register file, reg n in bits [32n+31:32n].
- `rd_count`, `wr_count`, `drop_count`  out  16 each  saturating event counters.

## Operation
- **FSM states:** IDLE, HDR2, DROP, TX0, TX1.
- **IDLE:** on an RX handshake, latch DW0/DW1.
  - Goes to HDR2 if all of: fmt[30:29] in {00 MRd3DW, 10 MWr3DW}, type[28:24] = 00000, BAR0 hit, tlast = 0.
  - Otherwise goes to DROP, or stays in IDLE if tlast = 1; in both cases `drop_count` increments.
- **HDR2:** on the RX handshake, DW2 (address) is in [31:0] and the write data is in [63:32]. The register index is addr[5:2].
  - **MWr, length = 1:** write the bytes enabled by first_be (DW1[3:0]). Index 0 is never written. `wr_count` increments. Go to IDLE if tlast, else DROP.
  - **MWr, length ≠ 1:** discard; increment `drop_count`.
  - **MRd:** latch the read data (ID_VALUE for index 0) and go to TX0 once tlast has been seen (via DROP if needed). `rd_count` increments only for length = 1.
- **DROP:** tready = 1; go to IDLE on a tlast handshake.
- **Completion for MRd, length = 1 (CplD):**
  - DW0: fmt 10, type 01010, TC/attr copied from the request, length 1.
  - DW1: {completer_id, status 000, BCM 0, byte_count}.
  - DW2: {requester_id, tag, 0, lower_addr}.
  - TX0 sends {DW1, DW0} with keep FF. TX1 sends {data, DW2} with keep FF and tlast.
- **Completion for MRd, length ≠ 1 (Cpl):** fmt 00, length 0, status 001 (UR), byte_count 4. TX1 keep = 0F.
- **byte_count** (from first_be, length 1):
  - 1xx1 → 4
  - 01x1 or 1x10 → 3
  - 0011, 0110, 1100 → 2
  - otherwise → 1
- **lower_addr:** {addr[6:2], index of lowest set bit of first_be}, or 00 if first_be = 0.
- **Counters:** saturate at FFFF and never wrap.

## Timing
- **Reset values:** state IDLE, regs 0, counters 0, tvalid/tlast 0, tdata/tkeep 0, m_axis_rx_tready 0 while reset is asserted.
- **RX ready:** m_axis_rx_tready = 1 in IDLE, HDR2 and DROP; 0 in TX0 and TX1. Only one TLP is in flight at a time.
- **Write commit:** at the HDR2 handshake edge; `regs_flat` reflects it the next cycle.
- **Read latency:** TX0 tvalid rises the cycle after the RX tlast handshake.
- **TX hold:** tvalid, tdata, tkeep and tlast stay stable until tready.
- **Return to RX:** after the TX1 handshake, state is IDLE and rx_tready = 1 on the following cycle.
- **Reset mid-operation:** an in-flight completion is abandoned asynchronously; tvalid goes 0 immediately.

## Test plan
- MWr reg3 = DEADBEEF (fbe F), then MRd reg3 tag 07 → CplD with DW1 byte_count 4, DW2 tag 07, lower_addr 0C, data DEADBEEF; wr_count = 1, rd_count = 1.
- MWr reg5 = 11223344 (fbe 0011) over existing AABBCCDD, then read → data AABB3344, byte_count 2.
- MRd length 2 → Cpl with status UR, length 0, TX1 keep 0F; rd_count unchanged.
- MWr to reg0 then MRd reg0 → data 5A430001 (ID_VALUE), reg0 unchanged.
- MRd with tready held low 5 cycles during TX0 → beat stable, then both beats delivered in order, rx_tready 0 throughout.
- Message TLP and a BAR1 MWr → both consumed, drop_count = 2, no TX traffic, registers unchanged.

Source files
------------

// File: rtl/pcie_bar_completer.sv
// BAR0 register-file completer for the 7-series PCIe endpoint AXI-Stream ports.
// Decodes 3DW MRd/MWr TLPs from the RX stream, maintains a 16 x 32-bit register
// file (register 0 is the read-only ID_VALUE) and returns one CplD/Cpl per MRd.
// Ports:
//   user_clk, user_reset_n        clock, async active-low reset
//   completer_id                  {bus, dev, fn} for completion headers
//   m_axis_rx_*                   RX TLP stream from the core (tuser[2] = BAR0 hit)
//   s_axis_tx_*                   TX completion stream to the core
//   regs_flat                     register file, reg n at [32n+31:32n]
//   rd_count/wr_count/drop_count  saturating event counters
module pcie_bar_completer #(
  parameter logic [31:0] ID_VALUE = 32'h5A43_0001
) (
  input  logic         user_clk,
  input  logic         user_reset_n,
  input  logic [15:0]  completer_id,
  input  logic [63:0]  m_axis_rx_tdata,
  input  logic [7:0]   m_axis_rx_tkeep,
  input  logic         m_axis_rx_tlast,
  input  logic         m_axis_rx_tvalid,
  input  logic [21:0]  m_axis_rx_tuser,
  output logic         m_axis_rx_tready,
  output logic [63:0]  s_axis_tx_tdata,
  output logic [7:0]   s_axis_tx_tkeep,
  output logic         s_axis_tx_tlast,
  output logic         s_axis_tx_tvalid,
  input  logic         s_axis_tx_tready,
  output logic [511:0] regs_flat,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count,
  output logic [15:0]  drop_count
);

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned DW_W     = 32;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR2,
    S_DROP,
    S_TX0,
    S_TX1
  } state_e;

  state_e             state_q, state_d;
  logic               rx_tready_q, rx_tready_d;
  logic               is_wr_q, is_wr_d;
  logic [9:0]         len_q, len_d;
  logic [2:0]         tc_q, tc_d;
  logic [1:0]         attr_q, attr_d;
  logic [15:0]        req_id_q, req_id_d;
  logic [7:0]         tag_q, tag_d;
  logic [3:0]         fbe_q, fbe_d;
  logic [4:0]         addr_q, addr_d;
  logic [DW_W-1:0]    rdata_q, rdata_d;
  logic               ur_q, ur_d;
  logic               pend_cpl_q, pend_cpl_d;
  logic [63:0]        tx_tdata_q, tx_tdata_d;
  logic [7:0]         tx_tkeep_q, tx_tkeep_d;
  logic               tx_tlast_q, tx_tlast_d;
  logic               tx_tvalid_q, tx_tvalid_d;
  logic [DW_W-1:0]    regs_q [NUM_REGS];
  logic [DW_W-1:0]    regs_d [NUM_REGS];
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic               rx_hs_c;
  logic               tx_hs_c;
  logic               hdr_ok_c;
  logic [3:0]         rx_idx_c;
  logic [DW_W-1:0]    cpl_dw0_c, cpl_dw1_c, cpl_dw2_c;
  logic               unused_rx_c;

  // Keep unused RX sideband/data bits visible to lint as intentionally ignored.
  assign unused_rx_c = ^{m_axis_rx_tkeep, m_axis_rx_tuser, m_axis_rx_tdata};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Byte count of a single-DW read from its first byte enables.
  function automatic logic [11:0] byte_count(input logic [3:0] be);
    logic [11:0] bc;
    casez (be)
      4'b1??1:                    bc = 12'd4;
      4'b01?1, 4'b1?10:           bc = 12'd3;
      4'b0011, 4'b0110, 4'b1100:  bc = 12'd2;
      default:                    bc = 12'd1;
    endcase
    return bc;
  endfunction

  // Index of the lowest enabled byte, 0 when no byte is enabled.
  function automatic logic [1:0] low_be(input logic [3:0] be);
    logic [1:0] r;
    if (be[0])      r = 2'd0;
    else if (be[1]) r = 2'd1;
    else if (be[2]) r = 2'd2;
    else if (be[3]) r = 2'd3;
    else            r = 2'd0;
    return r;
  endfunction

  assign rx_hs_c  = m_axis_rx_tvalid && rx_tready_q;
  assign tx_hs_c  = tx_tvalid_q && s_axis_tx_tready;
  assign rx_idx_c = m_axis_rx_tdata[5:2];
  assign hdr_ok_c = ((m_axis_rx_tdata[30:29] == 2'b00) || (m_axis_rx_tdata[30:29] == 2'b10)) &&
                    (m_axis_rx_tdata[28:24] == 5'b00000) && m_axis_rx_tuser[2] && !m_axis_rx_tlast;

  // Completion header DWs; ur_d covers the HDR2 -> TX0 shortcut where ur is still being latched.
  assign cpl_dw0_c = {1'b0, (ur_d ? 2'b00 : 2'b10), 5'b01010, 1'b0, tc_q, 4'b0000,
                      2'b00, attr_q, 2'b00, (ur_d ? 10'd0 : 10'd1)};
  assign cpl_dw1_c = {completer_id, (ur_d ? 3'b001 : 3'b000), 1'b0,
                      (ur_d ? 12'd4 : byte_count(fbe_q))};
  assign cpl_dw2_c = {req_id_q, tag_q, 1'b0, addr_q, low_be(fbe_q)};

  // Next-state, register-file and TX beat computation.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    len_d       = len_q;
    tc_d        = tc_q;
    attr_d      = attr_q;
    req_id_d    = req_id_q;
    tag_d       = tag_q;
    fbe_d       = fbe_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    ur_d        = ur_q;
    pend_cpl_d  = pend_cpl_q;
    tx_tdata_d  = tx_tdata_q;
    tx_tkeep_d  = tx_tkeep_q;
    tx_tlast_d  = tx_tlast_q;
    tx_tvalid_d = tx_tvalid_q;
    regs_d      = regs_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (rx_hs_c) begin
          is_wr_d    = m_axis_rx_tdata[30];
          len_d      = m_axis_rx_tdata[9:0];
          tc_d       = m_axis_rx_tdata[22:20];
          attr_d     = m_axis_rx_tdata[13:12];
          req_id_d   = m_axis_rx_tdata[63:48];
          tag_d      = m_axis_rx_tdata[47:40];
          fbe_d      = m_axis_rx_tdata[35:32];
          pend_cpl_d = 1'b0;
          if (hdr_ok_c) begin
            state_d = S_HDR2;
          end else begin
            drop_cnt_d = sat_inc(drop_cnt_q);
            state_d    = m_axis_rx_tlast ? S_IDLE : S_DROP;
          end
        end
      end
      S_HDR2: begin
        if (rx_hs_c) begin
          addr_d = m_axis_rx_tdata[6:2];
          if (is_wr_q) begin
            if (len_q == 10'd1) begin
              if (rx_idx_c != 4'd0) begin
                for (int b = 0; b < 4; b++) begin
                  if (fbe_q[b]) regs_d[rx_idx_c][b*8 +: 8] = m_axis_rx_tdata[32 + b*8 +: 8];
                end
              end
              wr_cnt_d = sat_inc(wr_cnt_q);
            end else begin
              drop_cnt_d = sat_inc(drop_cnt_q);
            end
            state_d = m_axis_rx_tlast ? S_IDLE : S_DROP;
          end else begin
            rdata_d    = (rx_idx_c == 4'd0) ? ID_VALUE : regs_q[rx_idx_c];
            ur_d       = (len_q != 10'd1);
            pend_cpl_d = 1'b1;
            if (len_q == 10'd1) rd_cnt_d = sat_inc(rd_cnt_q);
            state_d = m_axis_rx_tlast ? S_TX0 : S_DROP;
          end
        end
      end
      S_DROP: begin
        if (rx_hs_c && m_axis_rx_tlast) state_d = pend_cpl_q ? S_TX0 : S_IDLE;
      end
      S_TX0: begin
        if (tx_hs_c) begin
          state_d    = S_TX1;
          tx_tdata_d = {(ur_q ? 32'h0 : rdata_q), cpl_dw2_c};
          tx_tkeep_d = ur_q ? 8'h0F : 8'hFF;
          tx_tlast_d = 1'b1;
        end
      end
      S_TX1: begin
        if (tx_hs_c) begin
          state_d     = S_IDLE;
          pend_cpl_d  = 1'b0;
          tx_tvalid_d = 1'b0;
          tx_tlast_d  = 1'b0;
          tx_tdata_d  = 64'h0;
          tx_tkeep_d  = 8'h00;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // First completion beat is loaded on entry to TX0.
    if ((state_d == S_TX0) && (state_q != S_TX0)) begin
      tx_tvalid_d = 1'b1;
      tx_tdata_d  = {cpl_dw1_c, cpl_dw0_c};
      tx_tkeep_d  = 8'hFF;
      tx_tlast_d  = 1'b0;
    end
  end

  assign rx_tready_d = (state_d == S_IDLE) || (state_d == S_HDR2) || (state_d == S_DROP);

  // State and output registers.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q     <= S_IDLE;
      rx_tready_q <= 1'b0;
      is_wr_q     <= 1'b0;
      len_q       <= 10'd0;
      tc_q        <= 3'd0;
      attr_q      <= 2'd0;
      req_id_q    <= 16'd0;
      tag_q       <= 8'd0;
      fbe_q       <= 4'd0;
      addr_q      <= 5'd0;
      rdata_q     <= '0;
      ur_q        <= 1'b0;
      pend_cpl_q  <= 1'b0;
      tx_tdata_q  <= 64'h0;
      tx_tkeep_q  <= 8'h00;
      tx_tlast_q  <= 1'b0;
      tx_tvalid_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rx_tready_q <= rx_tready_d;
      is_wr_q     <= is_wr_d;
      len_q       <= len_d;
      tc_q        <= tc_d;
      attr_q      <= attr_d;
      req_id_q    <= req_id_d;
      tag_q       <= tag_d;
      fbe_q       <= fbe_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      ur_q        <= ur_d;
      pend_cpl_q  <= pend_cpl_d;
      tx_tdata_q  <= tx_tdata_d;
      tx_tkeep_q  <= tx_tkeep_d;
      tx_tlast_q  <= tx_tlast_d;
      tx_tvalid_q <= tx_tvalid_d;
      regs_q      <= regs_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Flatten the register file for fabric consumers.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DW_W +: DW_W] = regs_q[i];
  end

  assign m_axis_rx_tready = rx_tready_q;
  assign s_axis_tx_tdata  = tx_tdata_q;
  assign s_axis_tx_tkeep  = tx_tkeep_q;
  assign s_axis_tx_tlast  = tx_tlast_q;
  assign s_axis_tx_tvalid = tx_tvalid_q;
  assign rd_count         = rd_cnt_q;
  assign wr_count         = wr_cnt_q;
  assign drop_count       = drop_cnt_q;

endmodule

// File: tb/tb_pcie_bar_completer.sv
// Self-checking bench for pcie_bar_completer: directed plan items plus random
// MRd/MWr/drop traffic checked against a transaction-level register-file model.
module tb_pcie_bar_completer;

  localparam logic [31:0] ID_VAL = 32'h5A43_0001;
  localparam logic [15:0] CPL_ID = 16'h0A08;

  logic         user_clk = 1'b0;
  logic         user_reset_n;
  logic [15:0]  completer_id;
  logic [63:0]  m_axis_rx_tdata;
  logic [7:0]   m_axis_rx_tkeep;
  logic         m_axis_rx_tlast;
  logic         m_axis_rx_tvalid;
  logic [21:0]  m_axis_rx_tuser;
  logic         m_axis_rx_tready;
  logic [63:0]  s_axis_tx_tdata;
  logic [7:0]   s_axis_tx_tkeep;
  logic         s_axis_tx_tlast;
  logic         s_axis_tx_tvalid;
  logic         s_axis_tx_tready;
  logic [511:0] regs_flat;
  logic [15:0]  rd_count, wr_count, drop_count;

  pcie_bar_completer #(.ID_VALUE(ID_VAL)) dut (
    .user_clk         (user_clk),
    .user_reset_n     (user_reset_n),
    .completer_id     (completer_id),
    .m_axis_rx_tdata  (m_axis_rx_tdata),
    .m_axis_rx_tkeep  (m_axis_rx_tkeep),
    .m_axis_rx_tlast  (m_axis_rx_tlast),
    .m_axis_rx_tvalid (m_axis_rx_tvalid),
    .m_axis_rx_tuser  (m_axis_rx_tuser),
    .m_axis_rx_tready (m_axis_rx_tready),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tready (s_axis_tx_tready),
    .regs_flat        (regs_flat),
    .rd_count         (rd_count),
    .wr_count         (wr_count),
    .drop_count       (drop_count)
  );

  always #5 user_clk = ~user_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [31:0] m_regs [16];
  int m_rd, m_wr, m_drop, m_tx_beats;
  int tx_beats = 0;

  always @(posedge user_clk) if (s_axis_tx_tvalid && s_axis_tx_tready) tx_beats <= tx_beats + 1;

  function automatic int sat(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  // Byte count = span from lowest to highest enabled byte.
  function automatic int bc_model(input logic [3:0] be);
    int lo, hi;
    lo = -1; hi = -1;
    for (int b = 0; b < 4; b++) if (be[b]) begin if (lo < 0) lo = b; hi = b; end
    return (lo < 0) ? 1 : hi - lo + 1;
  endfunction

  function automatic logic [1:0] low_model(input logic [3:0] be);
    logic [1:0] r;
    r = 2'd0;
    for (int b = 3; b >= 0; b--) if (be[b]) r = 2'(b);
    return r;
  endfunction

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_rd = 0; m_wr = 0; m_drop = 0;
  endtask

  task automatic rx_beat(input logic [63:0] d, input logic last, input logic bar);
    int n;
    m_axis_rx_tdata  = d;
    m_axis_rx_tlast  = last;
    m_axis_rx_tkeep  = 8'hFF;
    m_axis_rx_tuser  = {19'h0, bar, 2'b00};
    m_axis_rx_tvalid = 1'b1;
    n = 0;
    @(negedge user_clk);
    while (!m_axis_rx_tready && n < 50) begin @(negedge user_clk); n++; end
    vectors++;
    if (m_axis_rx_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_accept_timeout: tready=%b required 1", m_axis_rx_tready);
    end
    @(posedge user_clk); #1;
    m_axis_rx_tvalid = 1'b0;
    m_axis_rx_tlast  = 1'b0;
  endtask

  // One TLP: drive it, predict its effect, check any completion and resulting state.
  task automatic xact(input logic [31:0] dw0, input logic [31:0] dw1, input logic [31:0] dw2,
                      input logic [31:0] wdata, input logic bar, input int nbeats, input int stall,
                      input string nm);
    logic [1:0] fmt; logic [4:0] typ; logic [9:0] len; logic [3:0] fbe; int idx;
    bit hdr_ok, is_rd, ur, first;
    logic [31:0] rd, r0, r1;
    logic [63:0] e0, e1, g0, g1, d;
    logic [7:0] k0, k1;
    logic l0, l1;
    int got, n;
    fmt = dw0[30:29]; typ = dw0[28:24]; len = dw0[9:0]; fbe = dw1[3:0]; idx = int'(dw2[5:2]);
    hdr_ok = ((fmt == 2'b00) || (fmt == 2'b10)) && (typ == 5'd0) && bar && (nbeats > 1);
    is_rd  = hdr_ok && (fmt == 2'b00);
    ur     = (len != 10'd1);
    rd     = 32'h0;
    if (!hdr_ok) m_drop = sat(m_drop);
    else if (fmt == 2'b10) begin
      if (!ur) begin
        if (idx != 0) for (int b = 0; b < 4; b++) if (fbe[b]) m_regs[idx][b*8 +: 8] = wdata[b*8 +: 8];
        m_wr = sat(m_wr);
      end else m_drop = sat(m_drop);
    end else begin
      rd = (idx == 0) ? ID_VAL : m_regs[idx];
      if (!ur) m_rd = sat(m_rd);
      m_tx_beats += 2;
    end
    r0 = (32'(ur ? 0 : 2) << 29) | (32'h0A << 24) | (32'(dw0[22:20]) << 20) |
         (32'(dw0[13:12]) << 12) | (ur ? 32'd0 : 32'd1);
    r1 = {CPL_ID, (ur ? 3'b001 : 3'b000), 1'b0, 12'(ur ? 4 : bc_model(fbe))};
    e0 = {r1, r0};
    e1 = {rd, dw1[31:16], dw1[15:8], 1'b0, dw2[6:2], low_model(fbe)};

    s_axis_tx_tready = (stall == 0);
    for (int i = 0; i < nbeats; i++) begin
      d = {32'($urandom), 32'($urandom)};
      if (i == 0) d = {dw1, dw0};
      if (i == 1) d = {wdata, dw2};
      rx_beat(d, (i == nbeats - 1), bar);
    end

    if (is_rd) begin
      vectors++;
      if (s_axis_tx_tvalid !== 1'b1 || m_axis_rx_tready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s cpl_latency: tvalid=%b rx_tready=%b required 1/0", nm, s_axis_tx_tvalid, m_axis_rx_tready);
      end
      for (int i = 0; i < stall; i++) begin
        @(negedge user_clk);
        vectors++;
        if (s_axis_tx_tvalid !== 1'b1 || s_axis_tx_tdata !== e0 || m_axis_rx_tready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s tx_hold: tvalid=%b tdata=%h rx_tready=%b required 1/%h/0", nm,
                   s_axis_tx_tvalid, s_axis_tx_tdata, m_axis_rx_tready, e0);
        end
      end
      s_axis_tx_tready = 1'b1;
      first = (stall > 0);
      got = 0; n = 0; g0 = '0; g1 = '0; k0 = '0; k1 = '0; l0 = 1'b0; l1 = 1'b0;
      while (got < 2 && n < 20) begin
        if (!first) @(negedge user_clk);
        first = 1'b0;
        n++;
        if (s_axis_tx_tvalid) begin
          if (m_axis_rx_tready !== 1'b0) begin
            vectors++; miscompares++;
            $display("FAIL %s rx_ready_during_tx: got %b required 0", nm, m_axis_rx_tready);
          end
          if (got == 0) begin g0 = s_axis_tx_tdata; k0 = s_axis_tx_tkeep; l0 = s_axis_tx_tlast; end
          else          begin g1 = s_axis_tx_tdata; k1 = s_axis_tx_tkeep; l1 = s_axis_tx_tlast; end
          got++;
        end
      end
      vectors++;
      if (got != 2) begin
        miscompares++;
        $display("FAIL %s tx_beats_timeout: got %0d beats required 2", nm, got);
      end
      @(posedge user_clk); #1;
      vectors++;
      if (s_axis_tx_tvalid !== 1'b0 || m_axis_rx_tready !== 1'b1) begin
        miscompares++;
        $display("FAIL %s return_to_rx: tvalid=%b rx_tready=%b required 0/1", nm, s_axis_tx_tvalid, m_axis_rx_tready);
      end
      vectors++;
      if (g0 !== e0 || k0 !== 8'hFF || l0 !== 1'b0) begin
        miscompares++;
        $display("FAIL %s cpl_beat0: data=%h keep=%h last=%b required %h/ff/0", nm, g0, k0, l0, e0);
      end
      vectors++;
      if (g1[31:0] !== e1[31:0] || k1 !== (ur ? 8'h0F : 8'hFF) || l1 !== 1'b1) begin
        miscompares++;
        $display("FAIL %s cpl_beat1: dw2=%h keep=%h last=%b required %h/%h/1", nm, g1[31:0], k1, l1,
                 e1[31:0], (ur ? 8'h0F : 8'hFF));
      end
      if (!ur) begin
        vectors++;
        if (g1[63:32] !== rd) begin
          miscompares++;
          $display("FAIL %s cpl_data: got %h required %h", nm, g1[63:32], rd);
        end
      end
    end else begin
      vectors++;
      if (s_axis_tx_tvalid !== 1'b0 || m_axis_rx_tready !== 1'b1) begin
        miscompares++;
        $display("FAIL %s no_tx_idle: tvalid=%b rx_tready=%b required 0/1", nm, s_axis_tx_tvalid, m_axis_rx_tready);
      end
    end

    vectors++;
    if (rd_count !== 16'(m_rd) || wr_count !== 16'(m_wr) || drop_count !== 16'(m_drop)) begin
      miscompares++;
      $display("FAIL %s counters: rd/wr/drop=%0d/%0d/%0d required %0d/%0d/%0d", nm,
               rd_count, wr_count, drop_count, m_rd, m_wr, m_drop);
    end
    vectors++;
    if (regs_flat !== model_flat()) begin
      miscompares++;
      $display("FAIL %s regs_flat: got %h required %h", nm, regs_flat, model_flat());
    end
  endtask

  function automatic logic [31:0] mk_dw0(input logic [1:0] fmt, input logic [4:0] typ,
                                         input logic [2:0] tc, input logic [1:0] attr, input logic [9:0] len);
    return {1'b0, fmt, typ, 1'b0, tc, 4'b0, 2'b00, attr, 2'b00, len};
  endfunction

  function automatic logic [31:0] mk_dw1(input logic [15:0] req, input logic [7:0] tag, input logic [3:0] fbe);
    return {req, tag, 4'h0, fbe};
  endfunction

  task automatic test_reset();
    user_reset_n = 1'b0;
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    vectors++;
    if (m_axis_rx_tready !== 1'b0 || s_axis_tx_tvalid !== 1'b0 || s_axis_tx_tlast !== 1'b0 ||
        s_axis_tx_tdata !== 64'h0 || s_axis_tx_tkeep !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: rx_tready=%b tvalid=%b tlast=%b tdata=%h tkeep=%h required all 0",
               m_axis_rx_tready, s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tdata, s_axis_tx_tkeep);
    end
    vectors++;
    if (regs_flat !== 512'h0 || rd_count !== 16'h0 || wr_count !== 16'h0 || drop_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: regs nonzero=%b rd/wr/drop=%0d/%0d/%0d required 0",
               (regs_flat != 512'h0), rd_count, wr_count, drop_count);
    end
    user_reset_n = 1'b1;
    model_reset();
    @(posedge user_clk); #1;
    vectors++;
    if (m_axis_rx_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b required 1", m_axis_rx_tready);
    end
  endtask

  task automatic test_plan();
    xact(mk_dw0(2'b10, 5'd0, 3'd0, 2'd0, 10'd1), mk_dw1(16'h0100, 8'h01, 4'hF), 32'h0000_000C,
         32'hDEADBEEF, 1'b1, 2, 0, "wr_reg3");
    xact(mk_dw0(2'b00, 5'd0, 3'd0, 2'd0, 10'd1), mk_dw1(16'h0100, 8'h07, 4'hF), 32'h0000_000C,
         32'h0, 1'b1, 2, 0, "rd_reg3");
    vectors++;
    if (rd_count !== 16'd1 || wr_count !== 16'd1) begin
      miscompares++;
      $display("FAIL plan_counts: rd=%0d wr=%0d required 1/1", rd_count, wr_count);
    end
    xact(mk_dw0(2'b10, 5'd0, 3'd0, 2'd0, 10'd1), mk_dw1(16'h0100, 8'h02, 4'hF), 32'h0000_0014,
         32'hAABBCCDD, 1'b1, 2, 0, "wr_reg5_full");
    xact(mk_dw0(2'b10, 5'd0, 3'd0, 2'd0, 10'd1), mk_dw1(16'h0100, 8'h03, 4'h3), 32'h0000_0014,
         32'h11223344, 1'b1, 2, 0, "wr_reg5_part");
    vectors++;
    if (regs_flat[5*32 +: 32] !== 32'hAABB3344) begin
      miscompares++;
      $display("FAIL partial_write: reg5=%h required aabb3344", regs_flat[5*32 +: 32]);
    end
    xact(mk_dw0(2'b00, 5'd0, 3'd2, 2'd1, 10'd1), mk_dw1(16'h0100, 8'h04, 4'h3), 32'h0000_0014,
         32'h0, 1'b1, 2, 0, "rd_reg5_part");
    xact(mk_dw0(2'b00, 5'd0, 3'd0, 2'd0, 10'd2), mk_dw1(16'h0100, 8'h05, 4'hF), 32'h0000_0014,
         32'h0, 1'b1, 2, 0, "rd_len2_ur");
    xact(mk_dw0(2'b10, 5'd0, 3'd0, 2'd0, 10'd1), mk_dw1(16'h0100, 8'h06, 4'hF), 32'h0000_0000,
         32'h12345678, 1'b1, 2, 0, "wr_reg0");
    xact(mk_dw0(2'b00, 5'd0, 3'd0, 2'd0, 10'd1), mk_dw1(16'h0100, 8'h08, 4'hF), 32'h0000_0000,
         32'h0, 1'b1, 2, 0, "rd_reg0");
    xact(mk_dw0(2'b00, 5'd0, 3'd7, 2'd3, 10'd1), mk_dw1(16'h0200, 8'h09, 4'hF), 32'h0000_004C,
         32'h0, 1'b1, 2, 5, "rd_stall5");
    xact(mk_dw0(2'b01, 5'b10100, 3'd0, 2'd0, 10'd1), mk_dw1(16'h0100, 8'h0A, 4'hF), 32'h0000_0018,
         32'hCAFEF00D, 1'b1, 2, 0, "msg_tlp");
    xact(mk_dw0(2'b10, 5'd0, 3'd0, 2'd0, 10'd1), mk_dw1(16'h0100, 8'h0B, 4'hF), 32'h0000_0018,
         32'hCAFEF00D, 1'b0, 2, 0, "bar1_wr");
  endtask

  task automatic test_random();
    int kind, nb, stall;
    logic [31:0] r, dw0, dw1, dw2;
    logic [1:0] fmt; logic [4:0] typ; logic [9:0] len; logic bar;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      r    = $urandom;
      len  = ($urandom_range(0, 4) == 0) ? r[25:16] : 10'd1;
      fmt  = (kind < 4) ? 2'b10 : 2'b00;
      typ  = 5'd0;
      bar  = 1'b1;
      nb   = 2 + $urandom_range(0, 2);
      if (kind == 8) begin fmt = r[30:29]; typ = 5'($urandom_range(1, 31)); end
      if (kind == 9) begin
        if (r[31]) bar = 1'b0; else nb = 1;
      end
      stall = $urandom_range(0, 3);
      dw0 = mk_dw0(fmt, typ, r[2:0], r[4:3], len);
      dw1 = mk_dw1(r[31:16], r[15:8], r[11:8]);
      dw2 = $urandom;
      dw2[1:0] = 2'b00;
      xact(dw0, dw1, dw2, $urandom, bar, nb, stall, "random");
    end
  endtask

  task automatic test_reset_mid();
    s_axis_tx_tready = 1'b0;
    rx_beat({mk_dw1(16'h0300, 8'h33, 4'hF), mk_dw0(2'b00, 5'd0, 3'd0, 2'd0, 10'd1)}, 1'b0, 1'b1);
    rx_beat({32'h0, 32'h0000_0008}, 1'b1, 1'b1);
    repeat (2) @(negedge user_clk);
    #2 user_reset_n = 1'b0;
    #1;
    vectors++;
    if (s_axis_tx_tvalid !== 1'b0 || m_axis_rx_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_abort: tvalid=%b rx_tready=%b required 0/0", s_axis_tx_tvalid, m_axis_rx_tready);
    end
    model_reset();
    repeat (2) @(negedge user_clk);
    user_reset_n = 1'b1;
    s_axis_tx_tready = 1'b1;
    @(posedge user_clk); #1;
    vectors++;
    if (m_axis_rx_tready !== 1'b1 || s_axis_tx_tvalid !== 1'b0 || rd_count !== 16'h0 || regs_flat !== 512'h0) begin
      miscompares++;
      $display("FAIL reset_mid_recover: rx_tready=%b tvalid=%b rd=%0d required 1/0/0",
               m_axis_rx_tready, s_axis_tx_tvalid, rd_count);
    end
    xact(mk_dw0(2'b10, 5'd0, 3'd0, 2'd0, 10'd1), mk_dw1(16'h0300, 8'h34, 4'hC), 32'h0000_0024,
         32'h89ABCDEF, 1'b1, 2, 0, "post_reset_wr");
    xact(mk_dw0(2'b00, 5'd0, 3'd0, 2'd0, 10'd1), mk_dw1(16'h0300, 8'h35, 4'h6), 32'h0000_0024,
         32'h0, 1'b1, 3, 1, "post_reset_rd");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    completer_id     = CPL_ID;
    m_axis_rx_tdata  = 64'h0;
    m_axis_rx_tkeep  = 8'h00;
    m_axis_rx_tlast  = 1'b0;
    m_axis_rx_tvalid = 1'b0;
    m_axis_rx_tuser  = 22'h0;
    s_axis_tx_tready = 1'b1;
    m_tx_beats       = 0;
    model_reset();
    test_reset();
    test_plan();
    test_random();
    test_reset_mid();
    @(negedge user_clk);
    vectors++;
    if (tx_beats !== m_tx_beats) begin
      miscompares++;
      $display("FAIL tx_beat_total: got %0d required %0d", tx_beats, m_tx_beats);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
